timer_controller: RTL

TIMER_CONTROLLER -- requirements
Module: timer_controller

---
 rtl/timer_controller_pkg.sv | 31 +++
 rtl/timer_controller_tick_divider.sv | 40 ++++
 rtl/timer_controller.sv | 136 +++++++++++++
 3 files changed

// File: rtl/timer_controller_pkg.sv
// -----------------------------------------------------------------------------
// timer_controller_pkg
// Shared definitions for the door/alarm timer controller:
//   - interval / param_sel encodings (SEL_*)
//   - default delay values in seconds (DEF_T_*)
//   - FSM state encoding (state_t)
//   - param_write_ok(): a reprogram value is usable only when non-zero
// -----------------------------------------------------------------------------
package timer_controller_pkg;

    localparam logic [1:0] SEL_ARM   = 2'b00;
    localparam logic [1:0] SEL_DRV   = 2'b01;
    localparam logic [1:0] SEL_PASS  = 2'b10;
    localparam logic [1:0] SEL_ALARM = 2'b11;

    localparam int unsigned DEF_T_ARM   = 32'd6;
    localparam int unsigned DEF_T_DRV   = 32'd8;
    localparam int unsigned DEF_T_PASS  = 32'd15;
    localparam int unsigned DEF_T_ALARM = 32'd10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    // A zero time would mean "expire immediately"; such writes are discarded.
    function automatic logic param_write_ok(input logic [3:0] value);
        return (value != 4'd0);
    endfunction

endpackage

// File: rtl/timer_controller_tick_divider.sv
// -----------------------------------------------------------------------------
// tick_divider
// Counts clock edges modulo DIV and flags the last count of each period.
// Ports:
//   i_clock  - system clock (rising edge)
//   i_reset  - synchronous active-high reset, counter -> 0
//   i_clear  - synchronous clear, counter -> 0 (restarts the period)
//   o_tick   - high for one cycle when the counter sits at DIV-1, i.e. the
//              next rising edge completes a full DIV-edge period
// -----------------------------------------------------------------------------
module tick_divider #(
    parameter int unsigned DIV = 32'd50_000_000
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    output logic o_tick
);

    localparam int unsigned W = (DIV > 32'd1) ? $clog2(DIV) : 32'd1;
    localparam logic [W-1:0] LAST = W'(DIV - 32'd1);

    logic [W-1:0] r_cnt;

    // Modulo-DIV edge counter with synchronous reset and clear.
    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Decoded from the counter register so the consumer acts on the very
    // edge that completes the period.
    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/timer_controller.sv
// -----------------------------------------------------------------------------
// timer_controller
// Seconds-based countdown timer with four programmable delays (arm, driver
// door, passenger door, alarm) and a free-running 1 Hz strobe.
// Ports:
//   clock          - system clock (rising edge)
//   reset          - synchronous active-high reset
//   start_timer    - load remaining from param[interval] and (re)start counting
//   interval[1:0]  - delay select sampled with start_timer
//   reprogram      - write time_value into param[param_sel] (ignored if 0)
//   param_sel[1:0] - reprogram target, same encoding as interval
//   time_value[3:0]- new delay in seconds
//   expired        - one-cycle pulse when a countdown completes
//   one_hz_enable  - one-cycle pulse every CLK_HZ edges, never restarted
//   busy           - countdown in progress
//   remaining[3:0] - seconds left in the current countdown
// -----------------------------------------------------------------------------
module timer_controller
    import timer_controller_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 32'd50_000_000,
    parameter int unsigned T_ARM_DEF   = DEF_T_ARM,
    parameter int unsigned T_DRV_DEF   = DEF_T_DRV,
    parameter int unsigned T_PASS_DEF  = DEF_T_PASS,
    parameter int unsigned T_ALARM_DEF = DEF_T_ALARM
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_timer,
    input  logic [1:0] interval,
    input  logic       reprogram,
    input  logic [1:0] param_sel,
    input  logic [3:0] time_value,
    output logic       expired,
    output logic       one_hz_enable,
    output logic       busy,
    output logic [3:0] remaining
);

    logic       w_free_tick;
    logic       w_cnt_tick;

    state_t     r_state;
    logic [3:0] r_param [4];
    logic [3:0] r_remaining;
    logic       r_expired;
    logic       r_busy;
    logic       r_one_hz;

    // Free-running divider behind one_hz_enable; only reset restarts it.
    tick_divider #(.DIV(CLK_HZ)) u_free_div (
        .i_clock (clock),
        .i_reset (reset),
        .i_clear (1'b0),
        .o_tick  (w_free_tick)
    );

    // Countdown prescaler, re-phased on every start so the first second is full.
    tick_divider #(.DIV(CLK_HZ)) u_count_div (
        .i_clock (clock),
        .i_reset (reset),
        .i_clear (start_timer),
        .o_tick  (w_cnt_tick)
    );

    // Registered 1 Hz strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_one_hz <= 1'b0;
        end else begin
            r_one_hz <= w_free_tick;
        end
    end

    // Parameter registers plus the IDLE/COUNT FSM with its registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state            <= ST_IDLE;
            r_remaining        <= 4'd0;
            r_expired          <= 1'b0;
            r_busy             <= 1'b0;
            r_param[SEL_ARM]   <= 4'(T_ARM_DEF);
            r_param[SEL_DRV]   <= 4'(T_DRV_DEF);
            r_param[SEL_PASS]  <= 4'(T_PASS_DEF);
            r_param[SEL_ALARM] <= 4'(T_ALARM_DEF);
        end else begin
            r_expired <= 1'b0;

            // Non-blocking write: a start on this edge still reads the old value.
            if (reprogram && param_write_ok(time_value)) begin
                r_param[param_sel] <= time_value;
            end else begin
                r_param[param_sel] <= r_param[param_sel];
            end

            // Start wins over everything, including a coincident final tick.
            if (start_timer) begin
                r_state     <= ST_COUNT;
                r_busy      <= 1'b1;
                r_remaining <= r_param[interval];
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_busy <= 1'b0;
                    end
                    ST_COUNT: begin
                        if (w_cnt_tick) begin
                            // <= 1 also covers a zero default, so no wrap.
                            if (r_remaining <= 4'd1) begin
                                r_remaining <= 4'd0;
                                r_state     <= ST_IDLE;
                                r_busy      <= 1'b0;
                                r_expired   <= 1'b1;
                            end else begin
                                r_remaining <= r_remaining - 4'd1;
                            end
                        end else begin
                            r_remaining <= r_remaining;
                        end
                    end
                    default: begin
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_remaining <= 4'd0;
                    end
                endcase
            end
        end
    end

    assign expired       = r_expired;
    assign one_hz_enable = r_one_hz;
    assign busy          = r_busy;
    assign remaining     = r_remaining;

endmodule
